alu_io_sequencer: RTL and testbench
===================================

// Module: alu_io_sequencer
// PURPOSE
//  Clocked front/back end around the ALU for the switch/LED test board.
//  Conditions raw SW, latches Input_Data into operand A, operand B and OP on
//  debounced switch edges, and lets the ALU settle. It then captures F and
//  ZF/CF/OF/SF/PF into a result register and drives the LED bus from it.
//  The ALU stays purely combinational and needs no edits.
// PARAMETERS
//  SIZE          32  data width; operands, result and LED bus are [SIZE:1]
//  DEB_CYCLES     4  cycles a synced SW bit must hold steady before accepted (>=1)
//  SETTLE_CYCLES  2  cycles the ALU inputs are held before the result capture (>=1)
// PORTS
//  clk          in   1       system clock, rising edge
//  rst_n        in   1       asynchronous active-low reset
//  SW           in   [5:0]   raw switches: [1] load A, [2] load B, [3] load OP, [4] show F, [5] show flags; [0] unused
//  Input_Data   in   [SIZE:1] operand/opcode value from the board switches
//  ALU_F        in   [SIZE:1] ALU result
//  ZF,CF,OF,SF,PF in 1       ALU flags
//  R_Data_A     out  [SIZE:1] operand A to the ALU
//  R_Data_B     out  [SIZE:1] operand B to the ALU
//  OP           out  [3:0]   opcode to the ALU
//  Result_Valid out  1       capture complete and no load since
//  Busy         out  1       FSM is in SETTLE
//  Output_Data  out  [SIZE:1] LED bus
// BEHAVIOUR
//  Reset (async, rst_n=0): all flops clear, so every output is 0 and the FSM goes to IDLE.
//  Input conditioning:
//   - SW passes through a 2-flop synchronizer, then a per-bit debouncer.
//   - The debounced bit updates only after the synced bit has differed from it
//     for DEB_CYCLES consecutive cycles. Any glitch resets that bit's counter.
//   - A debounced 0->1 transition on SW[1..3] makes a 1-cycle load pulse.
//  Load:
//   - In the cycle after a pulse, the register updates:
//     A <= Input_Data, B <= Input_Data, or OP <= Input_Data[4:1].
//   - Simultaneous pulses load every selected register in the same cycle.
//   - Loads are accepted in any FSM state.
//  FSM states: IDLE, SETTLE, CAPTURE.
//   - IDLE -> SETTLE on any load pulse; the settle counter loads SETTLE_CYCLES-1.
//   - SETTLE: the counter decrements. When it reaches 0, go to CAPTURE.
//     A new load pulse in SETTLE reloads the counter (restart).
//   - CAPTURE (1 cycle): res_f <= ALU_F and res_flags <= {ZF,CF,OF,SF,PF};
//     Result_Valid <= 1; then -> IDLE. A load pulse in CAPTURE still captures,
//     then goes to SETTLE instead of IDLE, with Result_Valid cleared.
//   - Result_Valid clears in the cycle after any load pulse.
//   - Busy = (state==SETTLE).
//   - Latency from the load pulse to Result_Valid=1 is SETTLE_CYCLES+2 cycles.
//  Display (registered, updated every cycle):
//   - debounced SW[5]=1: Output_Data <= {(SIZE-5)'b0, res_flags}. SW[5] wins over SW[4].
//   - else SW[4]=1: Output_Data <= res_f.
//   - else Output_Data holds its value.
//   - The LEDs show the captured result, never live ALU inputs, so they do not
//     change during SETTLE until CAPTURE.
//  No inferred latches; every register is clocked by clk with async clear by rst_n.
// TESTING
//  The bench stubs the ALU: it drives ALU_F=A+B and sets ZF=(A+B==0), with the other flags 0.
//  1. Reset mid-SETTLE: rst_n=0 -> all outputs 0 and state IDLE at once (before the next clk edge).
//  2. Input_Data=5, pulse SW[1]; Input_Data=3, pulse SW[2]; SW[4]=1 ->
//     R_Data_A=5, R_Data_B=3, Result_Valid=1 after SETTLE_CYCLES+2 cycles, Output_Data=8.
//  3. SW[1] glitch high for DEB_CYCLES-1 cycles -> no load; A is unchanged and state stays IDLE.
//  4. SW[4]=1 and SW[5]=1 with ALU_F=0, ZF=1 -> Output_Data=32'h0000_0010 (flags win).
//  5. Load pulse in the 2nd SETTLE cycle -> counter restarts; Result_Valid rises SETTLE_CYCLES+2 cycles after the 2nd pulse.
//  6. SW[1] and SW[2] rise together with Input_Data=7 -> A=B=7 in the same cycle; one capture; Output_Data=14 (SW[4]=1).

Source files
------------

// File: rtl/alu_io_sequencer.sv
// Clocked switch/LED front end for a combinational ALU: conditions the board switches,
// latches operands and opcode, waits for the ALU to settle, then captures and displays the result.
module alu_io_sequencer #(
    parameter int SIZE          = 32,
    parameter int DEB_CYCLES    = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [5:0]      SW,
    input  logic [SIZE:1]   Input_Data,
    input  logic [SIZE:1]   ALU_F,
    input  logic            ZF,
    input  logic            CF,
    input  logic            OF,
    input  logic            SF,
    input  logic            PF,
    output logic [SIZE:1]   R_Data_A,
    output logic [SIZE:1]   R_Data_B,
    output logic [3:0]      OP,
    output logic            Result_Valid,
    output logic            Busy,
    output logic [SIZE:1]   Output_Data
);

    localparam int DEB_W = $clog2(DEB_CYCLES + 1);
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    logic [5:1]      sw_meta_reg;
    logic [5:1]      sw_sync_reg;
    logic [5:1]      deb_bits;
    logic [3:1]      deb_prev_reg;
    logic [3:1]      load_pulse;
    logic            any_load;
    logic            unused_sw0;

    logic [SIZE:1]   r_data_a_reg;
    logic [SIZE:1]   r_data_b_reg;
    logic [3:0]      op_reg;

    state_t          state_reg;
    logic [SET_W-1:0] settle_cnt_reg;
    logic [SIZE:1]   res_f_reg;
    logic [4:0]      res_flags_reg;
    logic            result_valid_reg;
    logic            busy_reg;
    logic [SIZE:1]   output_data_reg;

    // SW[0] has no function on this board.
    assign unused_sw0 = SW[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta_reg <= '0;
            sw_sync_reg <= '0;
        end else begin
            sw_meta_reg <= SW[5:1];
            sw_sync_reg <= sw_meta_reg;
        end
    end

    // Per-bit debouncer: accept a new level only after it has been stable for DEB_CYCLES.
    genvar gi;
    generate
        for (gi = 1; gi <= 5; gi++) begin : g_deb
            logic [DEB_W-1:0] cnt_reg;
            logic             level_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg   <= '0;
                    level_reg <= 1'b0;
                end else if (sw_sync_reg[gi] != level_reg) begin
                    if (cnt_reg == DEB_W'(DEB_CYCLES - 1)) begin
                        level_reg <= sw_sync_reg[gi];
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + DEB_W'(1);
                    end
                end else begin
                    cnt_reg <= '0;
                end
            end

            assign deb_bits[gi] = level_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_prev_reg <= '0;
        end else begin
            deb_prev_reg <= deb_bits[3:1];
        end
    end

    assign load_pulse = deb_bits[3:1] & ~deb_prev_reg;
    assign any_load   = |load_pulse;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_a_reg <= '0;
            r_data_b_reg <= '0;
            op_reg       <= '0;
        end else begin
            if (load_pulse[1]) begin
                r_data_a_reg <= Input_Data;
            end
            if (load_pulse[2]) begin
                r_data_b_reg <= Input_Data;
            end
            if (load_pulse[3]) begin
                op_reg <= Input_Data[4:1];
            end
        end
    end

    // A load always (re)starts the settle window; CAPTURE samples the ALU even if a load arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            settle_cnt_reg   <= '0;
            res_f_reg        <= '0;
            res_flags_reg    <= '0;
            result_valid_reg <= 1'b0;
            busy_reg         <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (any_load) begin
                        state_reg        <= SETTLE;
                        settle_cnt_reg   <= SET_W'(SETTLE_CYCLES - 1);
                        result_valid_reg <= 1'b0;
                        busy_reg         <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (any_load) begin
                        settle_cnt_reg   <= SET_W'(SETTLE_CYCLES - 1);
                        result_valid_reg <= 1'b0;
                    end else if (settle_cnt_reg == '0) begin
                        state_reg <= CAPTURE;
                        busy_reg  <= 1'b0;
                    end else begin
                        settle_cnt_reg <= settle_cnt_reg - SET_W'(1);
                    end
                end
                CAPTURE: begin
                    res_f_reg     <= ALU_F;
                    res_flags_reg <= {ZF, CF, OF, SF, PF};
                    if (any_load) begin
                        state_reg        <= SETTLE;
                        settle_cnt_reg   <= SET_W'(SETTLE_CYCLES - 1);
                        result_valid_reg <= 1'b0;
                        busy_reg         <= 1'b1;
                    end else begin
                        state_reg        <= IDLE;
                        result_valid_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // LEDs only ever show captured values; flags take priority over the data word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            output_data_reg <= '0;
        end else if (deb_bits[5]) begin
            output_data_reg <= {{(SIZE - 5){1'b0}}, res_flags_reg};
        end else if (deb_bits[4]) begin
            output_data_reg <= res_f_reg;
        end
    end

    assign R_Data_A     = r_data_a_reg;
    assign R_Data_B     = r_data_b_reg;
    assign OP           = op_reg;
    assign Result_Valid = result_valid_reg;
    assign Busy         = busy_reg;
    assign Output_Data  = output_data_reg;

endmodule

// File: tb/tb_alu_io_sequencer.sv
// Bench for alu_io_sequencer: stubbed adder ALU, directed timing cases, a vector table
// and random transactions checked against a transaction-level model.
module tb_alu_io_sequencer;

    localparam int SIZE = 32;
    localparam int DEB  = 4;
    localparam int SET  = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [5:0]      sw;
    logic [SIZE:1]   input_data;
    logic [SIZE:1]   alu_f;
    logic            zf, cf, of, sf, pf;
    logic [SIZE:1]   r_data_a;
    logic [SIZE:1]   r_data_b;
    logic [3:0]      op;
    logic            result_valid;
    logic            busy;
    logic [SIZE:1]   output_data;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_a, m_b;
    logic [3:0]  m_op;

    typedef struct {
        logic [2:0]  mask;
        logic [31:0] data;
        logic        fl;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [3:0]  eop;
        logic [31:0] eout;
    } vec_t;

    vec_t vt [9];

    always #5 clk = ~clk;

    // ALU stub: adder with only the zero flag live.
    assign alu_f = r_data_a + r_data_b;
    assign zf    = (alu_f == '0);
    assign cf    = 1'b0;
    assign of    = 1'b0;
    assign sf    = 1'b0;
    assign pf    = 1'b0;

    alu_io_sequencer #(
        .SIZE          (SIZE),
        .DEB_CYCLES    (DEB),
        .SETTLE_CYCLES (SET)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .SW           (sw),
        .Input_Data   (input_data),
        .ALU_F        (alu_f),
        .ZF           (zf),
        .CF           (cf),
        .OF           (of),
        .SF           (sf),
        .PF           (pf),
        .R_Data_A     (r_data_a),
        .R_Data_B     (r_data_b),
        .OP           (op),
        .Result_Valid (result_valid),
        .Busy         (busy),
        .Output_Data  (output_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_out(input logic fl);
        logic [31:0] s;
        s = m_a + m_b;
        if (fl) return (s == 32'd0) ? 32'h0000_0010 : 32'h0;
        return s;
    endfunction

    // Press load switch mask m1 at step 0 and m2 at step t2; record first Busy and first Result_Valid after it.
    task automatic run_seq(input logic [2:0] m1, input int t2, input logic [2:0] m2,
                           output int busy_at, output int rv_at, output logic [31:0] out_at_busy);
        busy_at     = -1;
        rv_at       = -1;
        out_at_busy = '0;
        for (int i = 0; i < 80; i++) begin
            if (i == 0) sw[3:1] = sw[3:1] | m1;
            if (i == t2) sw[3:1] = sw[3:1] | m2;
            if (i == t2 + DEB + 4) sw[3:1] = 3'b000;
            tick();
            if (busy_at < 0 && busy) begin
                busy_at     = i;
                out_at_busy = output_data;
            end
            if (busy_at >= 0 && rv_at < 0 && result_valid) rv_at = i;
        end
    endtask

    task automatic apply_txn(input logic [2:0] mask, input logic [31:0] data, input logic fl);
        int n;
        sw[5]      = fl;
        sw[4]      = 1'b1;
        input_data = data;
        sw[3:1]    = mask;
        repeat (DEB + 2) tick();
        sw[3:1] = 3'b000;
        repeat (DEB + 3) tick();
        n = 0;
        while (!(result_valid && !busy) && n < 40) begin
            tick();
            n++;
        end
        check("txn_result_valid", {31'b0, result_valid}, 32'd1);
        repeat (2) tick();
    endtask

    initial begin
        int b_at, r_at, bad;
        logic [31:0] o_at, prev_out;
        logic [2:0]  rmask;
        logic [31:0] rdata;
        logic        rfl;

        vt[0] = '{3'b001, 32'd5,          1'b0, 32'd5,          32'd11,         4'h0, 32'd16};
        vt[1] = '{3'b010, 32'd3,          1'b0, 32'd5,          32'd3,          4'h0, 32'd8};
        vt[2] = '{3'b100, 32'h1234_567B,  1'b0, 32'd5,          32'd3,          4'hB, 32'd8};
        vt[3] = '{3'b011, 32'd7,          1'b0, 32'd7,          32'd7,          4'hB, 32'd14};
        vt[4] = '{3'b011, 32'd0,          1'b1, 32'd0,          32'd0,          4'hB, 32'h10};
        vt[5] = '{3'b001, 32'hFFFF_FFFF,  1'b0, 32'hFFFF_FFFF,  32'd0,          4'hB, 32'hFFFF_FFFF};
        vt[6] = '{3'b010, 32'd1,          1'b1, 32'hFFFF_FFFF,  32'd1,          4'hB, 32'h10};
        vt[7] = '{3'b100, 32'd5,          1'b0, 32'hFFFF_FFFF,  32'd1,          4'h5, 32'd0};
        vt[8] = '{3'b111, 32'h8000_0001,  1'b0, 32'h8000_0001,  32'h8000_0001,  4'h1, 32'd2};

        rst_n      = 1'b0;
        sw         = '0;
        input_data = '0;
        repeat (3) tick();
        check("reset_a", r_data_a, 32'd0);
        check("reset_b", r_data_b, 32'd0);
        check("reset_op", {28'b0, op}, 32'd0);
        check("reset_rv", {31'b0, result_valid}, 32'd0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_out", output_data, 32'd0);
        rst_n = 1'b1;
        tick();

        // Load A=5 then B=3, show F
        sw[4]      = 1'b1;
        input_data = 32'd5;
        run_seq(3'b001, 0, 3'b000, b_at, r_at, o_at);
        check("lat_a_busy_seen", {31'b0, b_at >= 0}, 32'd1);
        check("lat_a", r_at - b_at, SET + 1);
        input_data = 32'd3;
        run_seq(3'b010, 0, 3'b000, b_at, r_at, o_at);
        check("lat_b", r_at - b_at, SET + 1);
        m_a = 32'd5; m_b = 32'd3; m_op = 4'h0;
        check("t2_a", r_data_a, 32'd5);
        check("t2_b", r_data_b, 32'd3);
        check("t2_rv", {31'b0, result_valid}, 32'd1);
        check("t2_out", output_data, 32'd8);
        $display("txn directed A=5 B=3 out=%h", output_data);

        // Glitch shorter than the debounce window
        input_data = 32'd9;
        sw[1] = 1'b1;
        repeat (DEB - 1) tick();
        sw[1] = 1'b0;
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (busy) bad = 1;
        end
        check("glitch_no_settle", bad, 0);
        check("glitch_a_unchanged", r_data_a, m_a);
        $display("txn glitch A=%h busy_seen=%0d", r_data_a, bad);

        // Exactly DEB_CYCLES high is accepted
        sw[1] = 1'b1;
        repeat (DEB) tick();
        sw[1] = 1'b0;
        repeat (20) tick();
        m_a = 32'd9;
        check("deb_exact_a", r_data_a, m_a);
        check("deb_exact_out", output_data, model_out(1'b0));
        $display("txn deb_exact A=%h out=%h", r_data_a, output_data);

        // Second load in the 2nd SETTLE cycle restarts the window; LEDs hold during SETTLE
        prev_out   = output_data;
        input_data = 32'd11;
        run_seq(3'b001, 2, 3'b010, b_at, r_at, o_at);
        check("restart_lat", r_at - b_at, SET + 3);
        check("settle_led_hold", o_at, prev_out);
        m_a = 32'd11; m_b = 32'd11;
        check("restart_a", r_data_a, m_a);
        check("restart_b", r_data_b, m_b);
        check("restart_out", output_data, model_out(1'b0));
        $display("txn restart lat=%0d out=%h", r_at - b_at, output_data);

        for (int v = 0; v < 9; v++) begin
            apply_txn(vt[v].mask, vt[v].data, vt[v].fl);
            check("vec_a", r_data_a, vt[v].ea);
            check("vec_b", r_data_b, vt[v].eb);
            check("vec_op", {28'b0, op}, {28'b0, vt[v].eop});
            check("vec_out", output_data, vt[v].eout);
            $display("txn vec %0d mask=%b data=%h A=%h B=%h OP=%h out=%h",
                     v, vt[v].mask, vt[v].data, r_data_a, r_data_b, op, output_data);
        end
        m_a = 32'h8000_0001; m_b = 32'h8000_0001; m_op = 4'h1;

        for (int t = 0; t < 30; t++) begin
            rmask = 3'($urandom_range(1, 7));
            rfl   = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: rdata = 32'd0;
                1: rdata = (rmask[0]) ? (32'd0 - m_b) : (32'd0 - m_a);
                2: rdata = 32'($urandom_range(0, 255));
                default: rdata = $urandom;
            endcase
            apply_txn(rmask, rdata, rfl);
            if (rmask[0]) m_a = rdata;
            if (rmask[1]) m_b = rdata;
            if (rmask[2]) m_op = rdata[3:0];
            check("rnd_a", r_data_a, m_a);
            check("rnd_b", r_data_b, m_b);
            check("rnd_op", {28'b0, op}, {28'b0, m_op});
            check("rnd_out", output_data, model_out(rfl));
            $display("txn rnd %0d mask=%b data=%h fl=%b A=%h B=%h OP=%h out=%h",
                     t, rmask, rdata, rfl, r_data_a, r_data_b, op, output_data);
        end

        // Asynchronous reset while in SETTLE
        sw         = 6'b010000;
        input_data = 32'd42;
        sw[1]      = 1'b1;
        bad = 1;
        for (int i = 0; i < 30 && bad == 1; i++) begin
            tick();
            if (busy) bad = 0;
        end
        check("rst_reached_settle", bad, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_a", r_data_a, 32'd0);
        check("rst_async_b", r_data_b, 32'd0);
        check("rst_async_op", {28'b0, op}, 32'd0);
        check("rst_async_rv", {31'b0, result_valid}, 32'd0);
        check("rst_async_busy", {31'b0, busy}, 32'd0);
        check("rst_async_out", output_data, 32'd0);
        sw = '0;
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        check("post_rst_busy", {31'b0, busy}, 32'd0);
        check("post_rst_a", r_data_a, 32'd0);
        $display("txn reset_mid_settle busy=%b out=%h", busy, output_data);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
